sample_fifo: RTL
================

SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 The block SHALL have parameter pDATA_WIDTH, default 32, meaning the sample width in bits.
REQ-002 The block SHALL have parameter pDEPTH, default 16, meaning the FIFO entry count (power of 2, minimum 2).
REQ-003 The block SHALL have parameter pCNT_WIDTH, default 5, meaning the occupancy width, equal to log2(pDEPTH)+1.
REQ-004 Port axis_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port axis_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 Port ss_tvalid  input  1  upstream sample valid.
REQ-007 Port ss_tdata  input  pDATA_WIDTH  upstream sample, signed.
REQ-008 Port ss_tlast  input  1  upstream end-of-frame marker.
REQ-009 Port ss_tready  output  1  FIFO can accept a sample.
REQ-010 Port sm_tvalid  output  1  sample available to the FIR ss_* input.
REQ-011 Port sm_tdata  output  pDATA_WIDTH  sample to the FIR.
REQ-012 Port sm_tlast  output  1  end-of-frame to the FIR.
REQ-013 Port sm_tready  input  1  FIR accepts the sample.
REQ-014 Port data_length  input  32  expected frame length, matching the FIR 0x10 register; 0 disables length checking.
REQ-015 Port occupancy  output  pCNT_WIDTH  current entry count.
REQ-016 Port frame_cnt  output  16  count of frames emitted; wraps modulo 2^16.
REQ-017 Port len_err  output  1  one-cycle pulse on a frame-length mismatch.

Function
REQ-018 Push SHALL occur on a rising edge when ss_tvalid and ss_tready are both 1; pop SHALL occur on a rising edge when sm_tvalid and sm_tready are both 1.
REQ-019 Each entry SHALL store {tlast, tdata}.
REQ-020 ss_tready SHALL equal (occupancy < pDEPTH).
REQ-021 sm_tvalid SHALL equal (occupancy != 0).
REQ-022 sm_tdata SHALL be the head entry; when sm_tvalid is 0, sm_tdata SHALL hold the last value and is don't-care to the consumer.
REQ-023 First-word latency SHALL be 1 cycle: a push at edge k SHALL make sm_tvalid=1 after edge k into an empty FIFO.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-025 When full, ss_tready SHALL be 0; a same-cycle pop SHALL NOT enable a push in that cycle.
REQ-026 When empty, no pop SHALL occur; ss_tvalid with sm_tready SHALL NOT bypass the storage.
REQ-027 Read and write pointers SHALL wrap modulo pDEPTH.
REQ-028 Output index counter out_idx (32 bit) SHALL count popped samples within the current frame.
REQ-029 With data_length != 0: sm_tlast SHALL equal head.tlast OR (out_idx == data_length-1).
REQ-030 With data_length == 0: sm_tlast SHALL equal head.tlast.
REQ-031 On a pop where sm_tlast=1, out_idx SHALL clear to 0 and frame_cnt SHALL increment; otherwise, on a pop, out_idx SHALL increment.
REQ-032 len_err SHALL pulse for one cycle, on the cycle after a pop with data_length != 0 where head.tlast differs from (out_idx == data_length-1).
REQ-033 A change of data_length mid-frame SHALL take effect on the next pop comparison without clearing out_idx.
REQ-034 The FSM SHALL have states IDLE (occupancy=0, out_idx=0), STREAM (mid-frame or data queued), and LAST (head will be emitted with sm_tlast=1).
REQ-035 FSM transitions SHALL be: IDLE->STREAM on push; STREAM->LAST when the head qualifies for tlast; LAST->IDLE on pop if the FIFO becomes empty; LAST->STREAM on pop otherwise.

Reset
REQ-036 On axis_rst_n=0, pointers, occupancy, out_idx, frame_cnt, and len_err SHALL clear immediately, and the state SHALL be IDLE.
REQ-037 During reset, ss_tready SHALL be 1, sm_tvalid 0, sm_tlast 0, and sm_tdata 0.
REQ-038 Reset mid-frame SHALL discard all queued entries; the first post-reset pop SHALL be out_idx 0.
REQ-039 Memory contents need not be cleared.

Verification
REQ-040 data_length=600; push 600 ramp samples with tlast on #599; sm_tready=1 -> 600 samples in order, sm_tlast only on #599, frame_cnt=1, len_err never asserted.
REQ-041 sm_tready=0; push 17 samples -> occupancy=16, ss_tready=0 after the 16th push, 17th held; release -> all 17 emitted in order.
REQ-042 data_length=4; push 6 samples, no ss_tlast -> sm_tlast on #3; out_idx restarts; len_err pulses once, after pop #3.
REQ-043 data_length=8; ss_tlast on #4 -> sm_tlast on #4, len_err pulse, frame_cnt=1, next pop out_idx=0.
REQ-044 Alternate push/pop every cycle at occupancy 1 -> occupancy stays 1, no gaps in sm_tvalid.
REQ-045 Assert axis_rst_n=0 with 5 entries queued -> sm_tvalid=0 and occupancy=0 in the same cycle; after release, a new frame starts at index 0.

Source files
------------

// File: rtl/sample_fifo.sv
// Sample FIFO between an AXI-Stream source and the FIR input, with frame-length
// tracking: sm_tlast is forced at the expected length and mismatches pulse len_err.
module sample_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16,
  parameter int pCNT_WIDTH  = 5
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic                          ss_tvalid,
  input  logic signed [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                          ss_tlast,
  output logic                          ss_tready,
  output logic                          sm_tvalid,
  output logic signed [pDATA_WIDTH-1:0] sm_tdata,
  output logic                          sm_tlast,
  input  logic                          sm_tready,
  input  logic [31:0]                   data_length,
  output logic [pCNT_WIDTH-1:0]         occupancy,
  output logic [15:0]                   frame_cnt,
  output logic                          len_err
);

  localparam int unsigned lpPTR_W = $clog2(pDEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, LAST} state_t;

  logic [pDATA_WIDTH:0]          r_mem [pDEPTH];
  logic [lpPTR_W-1:0]            r_wr_ptr;
  logic [lpPTR_W-1:0]            r_rd_ptr;
  logic [pCNT_WIDTH-1:0]         r_count;
  logic [31:0]                   r_out_idx;
  logic [15:0]                   r_frame_cnt;
  logic                          r_len_err;
  logic signed [pDATA_WIDTH-1:0] r_hold;
  state_t                        r_state;
  state_t                        w_state_nxt;

  logic [pDATA_WIDTH:0]          w_head;
  logic [pCNT_WIDTH-1:0]         w_count_nxt;
  logic                          w_valid;
  logic                          w_ready;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_idx_hit;
  logic                          w_qualify;
  logic                          w_tlast;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_valid   = (r_count != '0);
  assign w_ready   = (r_count < pCNT_WIDTH'(pDEPTH));
  assign w_push    = ss_tvalid & w_ready;
  assign w_pop     = w_valid & sm_tready;
  assign w_idx_hit = (data_length != '0) && (r_out_idx == data_length - 32'd1);
  assign w_qualify = w_head[pDATA_WIDTH] | w_idx_hit;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + pCNT_WIDTH'(1);
      2'b01:   w_count_nxt = r_count - pCNT_WIDTH'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge axis_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {ss_tlast, ss_tdata};
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_idx   <= '0;
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_len_err <= w_pop && (data_length != '0) && (w_head[pDATA_WIDTH] != w_idx_hit);
      if (w_push) r_wr_ptr <= r_wr_ptr + lpPTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + lpPTR_W'(1);
        r_hold   <= w_head[pDATA_WIDTH-1:0];
        if (w_tlast) begin
          r_out_idx   <= '0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_out_idx <= r_out_idx + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_push) w_state_nxt = STREAM;
      STREAM: begin
        // A head can qualify and pop in the same cycle, skipping LAST.
        if (w_pop && w_tlast)          w_state_nxt = (w_count_nxt == '0) ? IDLE : STREAM;
        else if (w_valid && w_qualify) w_state_nxt = LAST;
      end
      LAST:   if (w_pop) w_state_nxt = (w_count_nxt == '0) ? IDLE : STREAM;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tlast = (r_state != IDLE) && w_valid && w_qualify;
  end

  assign ss_tready = w_ready;
  assign sm_tvalid = w_valid;
  assign sm_tdata  = w_valid ? w_head[pDATA_WIDTH-1:0] : r_hold;
  assign sm_tlast  = w_tlast;
  assign occupancy = r_count;
  assign frame_cnt = r_frame_cnt;
  assign len_err   = r_len_err;

endmodule
